// File: rtl/isp_awb_pkg.sv
// Shared constants and FSM encoding for the gray-world auto white balance stage.
// Gains are unsigned Q4.8: 12'h100 is unity and 12'hFFF is the largest gain.
package isp_awb_pkg;

    localparam int PIX_BITS = 8;
    localparam int GAIN_W   = 12;
    localparam int SUM_W    = PIX_BITS + 22;

    localparam logic [GAIN_W-1:0] GAIN_ONE = 12'h100;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV_R = 2'd1,
        DIV_B = 2'd2,
        PEND  = 2'd3
    } awb_state_t;

endpackage

// File: rtl/isp_awb_div.sv
// Serial restoring unsigned divider: one quotient bit per cycle, fixed latency.
// The quotient is clamped to GAIN_W bits; a zero divisor yields unity gain.
module isp_awb_div
    import isp_awb_pkg::*;
#(
    parameter int DIVIDEND_W = 38,
    parameter int DIVISOR_W  = 30
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [GAIN_W-1:0]     quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    // dq starts as the dividend; quotient bits shift in at the bottom as dividend bits leave the top.
    logic [DIVIDEND_W-1:0] dq;
    logic [DIVIDEND_W-1:0] dq_nxt;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    diff;
    logic [CNT_W-1:0]      cnt;
    logic                  div_zero;

    always_comb begin
        shifted = {rem, dq[DIVIDEND_W-1]};
        diff    = shifted - {1'b0, dsr};
        rem_nxt = shifted[DIVISOR_W-1:0];
        dq_nxt  = {dq[DIVIDEND_W-2:0], 1'b0};
        if (shifted >= {1'b0, dsr}) begin
            rem_nxt = diff[DIVISOR_W-1:0];
            dq_nxt  = {dq[DIVIDEND_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            dq       <= '0;
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                dq       <= dividend;
                rem      <= '0;
                dsr      <= divisor;
                div_zero <= (divisor == '0);
                cnt      <= CNT_W'(DIVIDEND_W);
                busy     <= 1'b1;
            end else if (busy) begin
                dq  <= dq_nxt;
                rem <= rem_nxt;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (div_zero)
                        quotient <= GAIN_ONE;
                    else if (|dq_nxt[DIVIDEND_W-1:GAIN_W])
                        quotient <= GAIN_MAX;
                    else
                        quotient <= dq_nxt[GAIN_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/isp_awb_gain.sv
// Gray-world AWB: accumulates per-channel frame sums, divides G/R and G/B between frames,
// commits gains at the next frame boundary and applies them through a 2-stage pipeline.
module isp_awb_gain
    import isp_awb_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int WIDTH     = 1936,
    parameter int HEIGHT    = 1088,
    parameter int GAIN_FRAC = 8
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                awb_en,
    input  logic                in_valid,
    input  logic [3*BITS-1:0]   in_color,
    output logic                out_valid,
    output logic [3*BITS-1:0]   out_color,
    output logic [GAIN_W-1:0]   gain_r,
    output logic [GAIN_W-1:0]   gain_b,
    output logic                stat_done
);

    localparam int NPIX       = WIDTH * HEIGHT;
    localparam int CNT_W      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int DVD_W      = SUM_W + GAIN_FRAC;
    localparam int PROD_W     = BITS + GAIN_W;
    localparam int ROUND_HALF = 1 << (GAIN_FRAC - 1);
    localparam int SAT_MAX    = (1 << BITS) - 1;

    logic [BITS-1:0]   in_r;
    logic [BITS-1:0]   in_g;
    logic [BITS-1:0]   in_b;
    logic [CNT_W-1:0]  pix_cnt;
    logic              last_pix;
    logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
    logic [SUM_W-1:0]  nxt_r, nxt_g, nxt_b;
    logic [SUM_W-1:0]  snap_r, snap_g, snap_b;
    awb_state_t        state;
    logic              accept;
    logic              div_kick;
    logic              div_busy;
    logic              div_done;
    logic [GAIN_W-1:0] div_quot;
    logic [DVD_W-1:0]  div_dividend;
    logic [SUM_W-1:0]  div_divisor;
    logic [GAIN_W-1:0] new_gain_r;
    logic [GAIN_W-1:0] new_gain_b;
    logic [GAIN_W-1:0] eff_r;
    logic [GAIN_W-1:0] eff_b;
    logic              s1_valid;
    logic [PROD_W-1:0] s1_prod_r;
    logic [PROD_W-1:0] s1_prod_b;
    logic [BITS-1:0]   s1_g;

    assign in_r     = in_color[3*BITS-1 -: BITS];
    assign in_g     = in_color[2*BITS-1 -: BITS];
    assign in_b     = in_color[BITS-1:0];
    assign last_pix = in_valid && (pix_cnt == CNT_W'(NPIX - 1));
    assign nxt_r    = sum_r + SUM_W'(in_r);
    assign nxt_g    = sum_g + SUM_W'(in_g);
    assign nxt_b    = sum_b + SUM_W'(in_b);

    // A frame end is only taken while the divider is free; otherwise that frame is skipped.
    assign accept   = last_pix && (state == ACCUM || state == PEND);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
        end else if (in_valid) begin
            if (last_pix) begin
                pix_cnt <= '0;
                sum_r   <= '0;
                sum_g   <= '0;
                sum_b   <= '0;
            end else begin
                pix_cnt <= pix_cnt + CNT_W'(1);
                sum_r   <= nxt_r;
                sum_g   <= nxt_g;
                sum_b   <= nxt_b;
            end
        end
    end

    assign div_dividend = {snap_g, {GAIN_FRAC{1'b0}}};
    assign div_divisor  = (state == DIV_B) ? snap_b : snap_r;

    isp_awb_div #(
        .DIVIDEND_W (DVD_W),
        .DIVISOR_W  (SUM_W)
    ) u_div (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .start    (div_kick),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // div_kick is held until the divider reports busy, so each launch is seen exactly once.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state      <= ACCUM;
            snap_r     <= '0;
            snap_g     <= '0;
            snap_b     <= '0;
            div_kick   <= 1'b0;
            new_gain_r <= GAIN_ONE;
            new_gain_b <= GAIN_ONE;
            gain_r     <= GAIN_ONE;
            gain_b     <= GAIN_ONE;
            stat_done  <= 1'b0;
        end else begin
            stat_done <= 1'b0;
            if (div_kick && div_busy)
                div_kick <= 1'b0;
            if (accept) begin
                snap_r   <= nxt_r;
                snap_g   <= nxt_g;
                snap_b   <= nxt_b;
                state    <= DIV_R;
                div_kick <= 1'b1;
            end else begin
                unique case (state)
                    ACCUM: ;
                    DIV_R: begin
                        if (div_done) begin
                            new_gain_r <= div_quot;
                            state      <= DIV_B;
                            div_kick   <= 1'b1;
                        end
                    end
                    DIV_B: begin
                        if (div_done) begin
                            new_gain_b <= div_quot;
                            state      <= PEND;
                            stat_done  <= 1'b1;
                        end
                    end
                    PEND: begin
                        if (pix_cnt == '0 && !in_valid) begin
                            gain_r <= new_gain_r;
                            gain_b <= new_gain_b;
                            state  <= ACCUM;
                        end
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

    function automatic logic [BITS-1:0] round_sat(input logic [PROD_W-1:0] p);
        logic [PROD_W:0] t;
        t = {1'b0, p} + (PROD_W + 1)'(ROUND_HALF);
        t = t >> GAIN_FRAC;
        if (t > (PROD_W + 1)'(SAT_MAX))
            return {BITS{1'b1}};
        return t[BITS-1:0];
    endfunction

    always_comb begin
        eff_r = awb_en ? gain_r : GAIN_ONE;
        eff_b = awb_en ? gain_b : GAIN_ONE;
    end

    // Stage 1 multiplies, stage 2 rounds and saturates; G rides along at unity.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_prod_r <= '0;
            s1_prod_b <= '0;
            s1_g      <= '0;
            out_valid <= 1'b0;
            out_color <= '0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_prod_r <= PROD_W'(in_r) * PROD_W'(eff_r);
                s1_prod_b <= PROD_W'(in_b) * PROD_W'(eff_b);
                s1_g      <= in_g;
            end
            if (s1_valid)
                out_color <= {round_sat(s1_prod_r), s1_g, round_sat(s1_prod_b)};
        end
    end

endmodule

// File: tb/tb_isp_awb_gain.sv
// Scoreboard bench for isp_awb_gain on a 4x2 frame: a gray-world reference model predicts
// every output pixel, the committed gains and the number of stat_done pulses.
module tb_isp_awb_gain;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        awb_en;
    logic        in_valid;
    logic [23:0] in_color;
    logic        out_valid;
    logic [23:0] out_color;
    logic [11:0] gain_r;
    logic [11:0] gain_b;
    logic        stat_done;

    int          checks = 0;
    int          passes = 0;
    logic [23:0] exp_q[$];
    int          stat_seen = 0;
    int          stat_expected = 0;
    int          committed_r = 256;
    int          committed_b = 256;
    int          pending_r = 256;
    int          pending_b = 256;
    bit          pending_valid = 0;
    longint      sr = 0;
    longint      sg = 0;
    longint      sb = 0;
    logic [23:0] frm[NPIX];

    always #5 pclk = ~pclk;

    isp_awb_gain #(
        .BITS      (8),
        .WIDTH     (W),
        .HEIGHT    (H),
        .GAIN_FRAC (8)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .awb_en    (awb_en),
        .in_valid  (in_valid),
        .in_color  (in_color),
        .out_valid (out_valid),
        .out_color (out_color),
        .gain_r    (gain_r),
        .gain_b    (gain_b),
        .stat_done (stat_done)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic int calcGain(input longint green_sum, input longint chan_sum);
        longint q;
        if (chan_sum == 0)
            return 256;
        q = (green_sum * 256) / chan_sum;
        if (q > 4095)
            return 4095;
        return int'(q);
    endfunction

    function automatic logic [7:0] applyGain(input int c, input int g);
        int v;
        v = (c * g + 128) / 256;
        if (v > 255)
            v = 255;
        return 8'(v);
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            in_valid = 1'b0;
            in_color = 24'($urandom);
            awb_en   = 1'($urandom);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] px, input logic en);
        int er;
        int eb;
        @(posedge pclk);
        #1;
        in_valid = 1'b1;
        in_color = px;
        awb_en   = en;
        er = en ? committed_r : 256;
        eb = en ? committed_b : 256;
        exp_q.push_back({applyGain(int'(px[23:16]), er), px[15:8], applyGain(int'(px[7:0]), eb)});
        sr += px[23:16];
        sg += px[15:8];
        sb += px[7:0];
    endtask

    task automatic fillFrame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int i = 0; i < NPIX; i++)
            frm[i] = {r, g, b};
    endtask

    task automatic randomFrame();
        for (int i = 0; i < NPIX; i++)
            frm[i] = 24'($urandom);
    endtask

    // en_mode: 0 bypass, 1 apply, 2 random per pixel. spacing < 0 picks 0..2 idle cycles.
    // skipped marks a frame whose statistics never produce gains.
    task automatic runFrame(input int en_mode, input int spacing, input bit skipped);
        logic en;
        for (int i = 0; i < NPIX; i++) begin
            en = (en_mode == 2) ? 1'($urandom) : 1'(en_mode);
            applyStimulus(frm[i], en);
            if (i < NPIX - 1)
                idleCycles(spacing < 0 ? $urandom_range(0, 2) : spacing);
        end
        if (!skipped) begin
            pending_r     = calcGain(sg, sr);
            pending_b     = calcGain(sg, sb);
            pending_valid = 1;
            stat_expected++;
        end
        sr = 0;
        sg = 0;
        sb = 0;
    endtask

    task automatic frameGap();
        idleCycles(200);
        if (pending_valid) begin
            committed_r   = pending_r;
            committed_b   = pending_b;
            pending_valid = 0;
        end
        checkOutput("gain_r", gain_r, committed_r);
        checkOutput("gain_b", gain_b, committed_b);
        checkOutput("stat_done count", stat_seen, stat_expected);
    endtask

    initial begin : monitor
        logic [23:0] e;
        forever begin
            @(negedge pclk);
            if (stat_done)
                stat_seen++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected out_valid: got out_color 0x%0h, expected no output", out_color);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_color", out_color, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_color = '0;
        awb_en   = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_color", out_color, 0);
        checkOutput("reset gain_r", gain_r, 12'h100);
        checkOutput("reset gain_b", gain_b, 12'h100);
        checkOutput("reset stat_done", stat_done, 0);
        rst_n = 1'b1;
        idleCycles(5);

        $display("[TB] uniform frame, then gained frame with a saturating pixel");
        fillFrame(8'd64, 8'd128, 8'd32);
        runFrame(1, 0, 0);
        frameGap();
        checkOutput("frame1 gain_r", gain_r, 12'h200);
        checkOutput("frame1 gain_b", gain_b, 12'h400);
        fillFrame(8'd64, 8'd128, 8'd32);
        frm[5] = {8'd200, 8'd100, 8'd100};
        runFrame(1, 1, 0);
        frameGap();

        $display("[TB] zero red sum");
        fillFrame(8'd0, 8'd128, 8'd64);
        runFrame(2, -1, 0);
        frameGap();
        checkOutput("zero divisor gain_r", gain_r, 12'h100);
        checkOutput("zero divisor gain_b", gain_b, 12'h200);

        $display("[TB] gain clamp");
        fillFrame(8'd1, 8'd255, 8'd255);
        runFrame(1, 0, 0);
        frameGap();
        checkOutput("clamped gain_r", gain_r, 12'hFFF);
        fillFrame(8'd1, 8'd200, 8'd50);
        runFrame(1, 0, 0);
        frameGap();

        $display("[TB] bypass while stats keep running");
        fillFrame(8'd64, 8'd128, 8'd32);
        runFrame(1, 0, 0);
        frameGap();
        randomFrame();
        runFrame(0, -1, 0);
        frameGap();

        $display("[TB] frame end during divide is skipped");
        randomFrame();
        runFrame(1, 0, 0);
        randomFrame();
        runFrame(1, 0, 1);
        frameGap();

        $display("[TB] frame end while results are pending replaces them");
        randomFrame();
        runFrame(1, 0, 0);
        randomFrame();
        runFrame(1, 12, 0);
        frameGap();

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            randomFrame();
            runFrame(2, -1, 0);
            frameGap();
        end

        $display("[TB] reset during divide");
        randomFrame();
        runFrame(1, 0, 1);
        idleCycles(12);
        rst_n = 1'b0;
        idleCycles(3);
        rst_n = 1'b1;
        committed_r   = 256;
        committed_b   = 256;
        pending_valid = 0;
        checkOutput("post-reset gain_r", gain_r, 12'h100);
        checkOutput("post-reset gain_b", gain_b, 12'h100);
        frameGap();
        randomFrame();
        runFrame(1, -1, 0);
        frameGap();

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(posedge pclk);
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
